ip_tx_noc_in_parser: RTL and testbench

//  Receive end of the IP_TX_DATAGRAM NoC message. Accepts header flit, one
//  ip_tx_metadata_flit and ceil(len/NOC_DATA_BYTES) data flits from NoC0.

---
 rtl/ip_tx_noc_in_pkg.sv | 51 +++++
 rtl/ip_tx_noc_in_parser_datap.sv | 130 +++++++++++++
 rtl/ip_tx_noc_in_parser.sv | 144 ++++++++++++++
 tb/tb_ip_tx_noc_in_parser.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_tx_noc_in_pkg.sv
// Shared types for the IP TX NoC input parser: flit layouts, widths and FSM states.
package ip_tx_noc_in_pkg;

  localparam int NOC_DATA_WIDTH   = 512;
  localparam int NOC_DATA_BYTES   = NOC_DATA_WIDTH / 8;
  localparam int NOC_BYTES_W      = $clog2(NOC_DATA_BYTES);
  localparam int MAC_INTERFACE_W  = NOC_DATA_WIDTH;
  localparam int MAC_PADBYTES_W   = NOC_BYTES_W;
  localparam int IP_ADDR_W        = 32;
  localparam int TOT_LEN_W        = 16;
  localparam int PROTOCOL_W       = 8;
  localparam int XY_WIDTH         = 8;
  localparam int MSG_LENGTH_WIDTH = 16;
  localparam int MSG_TYPE_W       = 8;

  localparam logic [MSG_TYPE_W-1:0] IP_TX_DATAGRAM = 8'h0c;

  localparam logic [2:0] ST_RX_HDR   = 3'd0;
  localparam logic [2:0] ST_RX_META  = 3'd1;
  localparam logic [2:0] ST_META_OUT = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_DRAIN    = 3'd4;

  typedef enum logic [2:0] {
    RX_HDR   = ST_RX_HDR,
    RX_META  = ST_RX_META,
    META_OUT = ST_META_OUT,
    DATA     = ST_DATA,
    DRAIN    = ST_DRAIN
  } parser_state_e;

  typedef struct packed {
    logic [XY_WIDTH-1:0]         dst_x;
    logic [XY_WIDTH-1:0]         dst_y;
    logic [MSG_LENGTH_WIDTH-1:0] msg_len;
    logic [MSG_TYPE_W-1:0]       msg_type;
    logic [XY_WIDTH-1:0]         src_x;
    logic [XY_WIDTH-1:0]         src_y;
    logic [7:0]                  metadata_flits;
    logic [NOC_DATA_WIDTH-64-1:0] pad;
  } beehive_noc_hdr_flit;

  typedef struct packed {
    logic [IP_ADDR_W-1:0]  src_ip;
    logic [IP_ADDR_W-1:0]  dst_ip;
    logic [TOT_LEN_W-1:0]  data_payload_len;
    logic [PROTOCOL_W-1:0] protocol;
    logic [NOC_DATA_WIDTH-88-1:0] pad;
  } ip_tx_metadata_flit;

endpackage

// File: rtl/ip_tx_noc_in_parser_datap.sv
// Datapath of the parser: header checks, metadata registers, beat/drain counters
// and tail padding for the final beat.
module ip_tx_noc_in_parser_datap
  import ip_tx_noc_in_pkg::*;
#(
  parameter int SRC_X = -1,
  parameter int SRC_Y = -1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NOC_DATA_WIDTH-1:0]   flit_i,
  input  logic                        store_hdr_i,
  input  logic                        store_meta_i,
  input  logic                        load_drain_i,
  input  logic                        dec_data_i,
  input  logic                        dec_drain_i,
  output logic                        hdr_ok_o,
  output logic                        hdr_len_zero_o,
  output logic                        data_cnt_zero_o,
  output logic                        data_cnt_one_o,
  output logic                        drain_cnt_one_o,
  output logic [IP_ADDR_W-1:0]        src_ip_o,
  output logic [IP_ADDR_W-1:0]        dst_ip_o,
  output logic [TOT_LEN_W-1:0]        payload_len_o,
  output logic [PROTOCOL_W-1:0]       protocol_o,
  output logic [XY_WIDTH-1:0]         src_x_o,
  output logic [XY_WIDTH-1:0]         src_y_o,
  output logic [MAC_PADBYTES_W-1:0]   padbytes_o
);

  localparam logic [XY_WIDTH-1:0]         OWN_X   = XY_WIDTH'(SRC_X);
  localparam logic [XY_WIDTH-1:0]         OWN_Y   = XY_WIDTH'(SRC_Y);
  localparam logic [MSG_LENGTH_WIDTH-1:0] CNT_ONE = MSG_LENGTH_WIDTH'(1);

  beehive_noc_hdr_flit hdr;
  ip_tx_metadata_flit  meta;
  logic                unused_flit_bits;

  assign hdr  = flit_i;
  assign meta = flit_i;
  assign unused_flit_bits = ^{hdr.pad, meta.pad};

  logic [IP_ADDR_W-1:0]        src_ip_q, src_ip_d;
  logic [IP_ADDR_W-1:0]        dst_ip_q, dst_ip_d;
  logic [TOT_LEN_W-1:0]        len_q, len_d;
  logic [PROTOCOL_W-1:0]       proto_q, proto_d;
  logic [XY_WIDTH-1:0]         src_x_q, src_x_d;
  logic [XY_WIDTH-1:0]         src_y_q, src_y_d;
  logic [MSG_LENGTH_WIDTH-1:0] data_cnt_q, data_cnt_d;
  logic [MSG_LENGTH_WIDTH-1:0] drain_cnt_q, drain_cnt_d;
  logic [MSG_LENGTH_WIDTH-1:0] beats_calc;
  logic [NOC_BYTES_W-1:0]      meta_len_low;
  logic [NOC_BYTES_W-1:0]      len_low;

  assign hdr_ok_o = (hdr.msg_type == IP_TX_DATAGRAM) && (hdr.metadata_flits == 8'd1) &&
                    (hdr.dst_x == OWN_X) && (hdr.dst_y == OWN_Y);
  assign hdr_len_zero_o = (hdr.msg_len == '0);

  // A partial trailing flit still costs a whole beat.
  assign meta_len_low = meta.data_payload_len[NOC_BYTES_W-1:0];
  assign beats_calc   = MSG_LENGTH_WIDTH'(meta.data_payload_len >> NOC_BYTES_W) +
                        MSG_LENGTH_WIDTH'(meta_len_low != '0);

  always_comb begin
    src_ip_d    = src_ip_q;
    dst_ip_d    = dst_ip_q;
    len_d       = len_q;
    proto_d     = proto_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    data_cnt_d  = data_cnt_q;
    drain_cnt_d = drain_cnt_q;
    if (store_hdr_i) begin
      src_x_d = hdr.src_x;
      src_y_d = hdr.src_y;
    end
    if (load_drain_i) begin
      drain_cnt_d = hdr.msg_len;
    end else if (dec_drain_i && drain_cnt_q != '0) begin
      drain_cnt_d = drain_cnt_q - CNT_ONE;
    end
    if (store_meta_i) begin
      src_ip_d   = meta.src_ip;
      dst_ip_d   = meta.dst_ip;
      len_d      = meta.data_payload_len;
      proto_d    = meta.protocol;
      data_cnt_d = beats_calc;
    end else if (dec_data_i && data_cnt_q != '0) begin
      data_cnt_d = data_cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_ip_q    <= '0;
      dst_ip_q    <= '0;
      len_q       <= '0;
      proto_q     <= '0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      data_cnt_q  <= '0;
      drain_cnt_q <= '0;
    end else begin
      src_ip_q    <= src_ip_d;
      dst_ip_q    <= dst_ip_d;
      len_q       <= len_d;
      proto_q     <= proto_d;
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      data_cnt_q  <= data_cnt_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  assign data_cnt_zero_o = (data_cnt_q == '0);
  assign data_cnt_one_o  = (data_cnt_q == CNT_ONE);
  assign drain_cnt_one_o = (drain_cnt_q == CNT_ONE);

  // Pad width equals the byte-offset width, so 0 - low wraps to NOC_DATA_BYTES - low.
  assign len_low    = len_q[NOC_BYTES_W-1:0];
  assign padbytes_o = (data_cnt_one_o && len_low != '0) ? (MAC_PADBYTES_W'(0) - len_low) : '0;

  assign src_ip_o      = src_ip_q;
  assign dst_ip_o      = dst_ip_q;
  assign payload_len_o = len_q;
  assign protocol_o    = proto_q;
  assign src_x_o       = src_x_q;
  assign src_y_o       = src_y_q;

endmodule

// File: rtl/ip_tx_noc_in_parser.sv
// IP_TX_DATAGRAM receive parser: header + metadata flit in, metadata out on
// val/rdy, then payload beats passed straight through with last/padbytes.
module ip_tx_noc_in_parser
  import ip_tx_noc_in_pkg::*;
#(
  parameter int SRC_X = -1,
  parameter int SRC_Y = -1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       noc0_ctovr_parser_val,
  input  logic [NOC_DATA_WIDTH-1:0]  noc0_ctovr_parser_data,
  output logic                       parser_noc0_ctovr_rdy,
  output logic                       parser_dst_meta_val,
  output logic [IP_ADDR_W-1:0]       parser_dst_src_ip,
  output logic [IP_ADDR_W-1:0]       parser_dst_dst_ip,
  output logic [TOT_LEN_W-1:0]       parser_dst_payload_len,
  output logic [PROTOCOL_W-1:0]      parser_dst_protocol,
  output logic [XY_WIDTH-1:0]        parser_dst_src_x,
  output logic [XY_WIDTH-1:0]        parser_dst_src_y,
  input  logic                       dst_parser_meta_rdy,
  output logic                       parser_dst_data_val,
  output logic [MAC_INTERFACE_W-1:0] parser_dst_data,
  output logic                       parser_dst_data_last,
  output logic [MAC_PADBYTES_W-1:0]  parser_dst_data_padbytes,
  input  logic                       dst_parser_data_rdy,
  output logic                       parser_err_drop,
  output logic [2:0]                 dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where val and rdy are both 1;
  // val never depends on rdy of the same interface, and payload moves through
  // combinationally so NoC rdy mirrors the downstream data rdy in DATA.

  logic [2:0] state_q, state_d;
  logic       err_q, err_d;
  logic       store_hdr, store_meta, load_drain, dec_data, dec_drain;
  logic       hdr_ok, hdr_len_zero, data_cnt_zero, data_cnt_one, drain_cnt_one;
  logic [MAC_PADBYTES_W-1:0] padbytes;
  logic       in_data;

  ip_tx_noc_in_parser_datap #(
    .SRC_X (SRC_X),
    .SRC_Y (SRC_Y)
  ) u_datap (
    .clk             (clk),
    .rst_n           (rst_n),
    .flit_i          (noc0_ctovr_parser_data),
    .store_hdr_i     (store_hdr),
    .store_meta_i    (store_meta),
    .load_drain_i    (load_drain),
    .dec_data_i      (dec_data),
    .dec_drain_i     (dec_drain),
    .hdr_ok_o        (hdr_ok),
    .hdr_len_zero_o  (hdr_len_zero),
    .data_cnt_zero_o (data_cnt_zero),
    .data_cnt_one_o  (data_cnt_one),
    .drain_cnt_one_o (drain_cnt_one),
    .src_ip_o        (parser_dst_src_ip),
    .dst_ip_o        (parser_dst_dst_ip),
    .payload_len_o   (parser_dst_payload_len),
    .protocol_o      (parser_dst_protocol),
    .src_x_o         (parser_dst_src_x),
    .src_y_o         (parser_dst_src_y),
    .padbytes_o      (padbytes)
  );

  always_comb begin
    state_d               = state_q;
    err_d                 = 1'b0;
    parser_noc0_ctovr_rdy = 1'b0;
    parser_dst_meta_val   = 1'b0;
    parser_dst_data_val   = 1'b0;
    store_hdr             = 1'b0;
    store_meta            = 1'b0;
    load_drain            = 1'b0;
    dec_data              = 1'b0;
    dec_drain             = 1'b0;
    case (state_q)
      ST_RX_HDR: begin
        parser_noc0_ctovr_rdy = 1'b1;
        if (noc0_ctovr_parser_val) begin
          store_hdr = 1'b1;
          if (hdr_ok) begin
            state_d = ST_RX_META;
          end else begin
            err_d = 1'b1;
            if (!hdr_len_zero) begin
              load_drain = 1'b1;
              state_d    = ST_DRAIN;
            end
          end
        end
      end
      ST_RX_META: begin
        parser_noc0_ctovr_rdy = 1'b1;
        if (noc0_ctovr_parser_val) begin
          store_meta = 1'b1;
          state_d    = ST_META_OUT;
        end
      end
      ST_META_OUT: begin
        parser_dst_meta_val = 1'b1;
        if (dst_parser_meta_rdy) begin
          state_d = data_cnt_zero ? ST_RX_HDR : ST_DATA;
        end
      end
      ST_DATA: begin
        parser_dst_data_val   = noc0_ctovr_parser_val;
        parser_noc0_ctovr_rdy = dst_parser_data_rdy;
        if (noc0_ctovr_parser_val && dst_parser_data_rdy) begin
          dec_data = 1'b1;
          if (data_cnt_one) state_d = ST_RX_HDR;
        end
      end
      ST_DRAIN: begin
        parser_noc0_ctovr_rdy = 1'b1;
        if (noc0_ctovr_parser_val) begin
          dec_drain = 1'b1;
          if (drain_cnt_one) state_d = ST_RX_HDR;
        end
      end
      default: state_d = ST_RX_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RX_HDR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  assign in_data                  = (state_q == ST_DATA);
  assign parser_dst_data          = noc0_ctovr_parser_data;
  assign parser_dst_data_last     = in_data && data_cnt_one;
  assign parser_dst_data_padbytes = in_data ? padbytes : '0;
  assign parser_err_drop          = err_q;
  assign dbg_state_o              = state_q;

endmodule

// File: tb/tb_ip_tx_noc_in_parser.sv
// Bench for ip_tx_noc_in_parser: vector table, hand sequences and randomized
// messages checked against a message-level reference model.
module tb_ip_tx_noc_in_parser;
  import ip_tx_noc_in_pkg::*;

  localparam int SX     = 3;
  localparam int SY     = 5;
  localparam int W      = NOC_DATA_WIDTH;
  localparam int BEAT_W = 1 + MAC_PADBYTES_W + W;
  localparam int META_W = 2 * IP_ADDR_W + TOT_LEN_W + PROTOCOL_W + 2 * XY_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic noc_val = 1'b0;
  logic [W-1:0] noc_data = '0;
  logic noc_rdy;
  logic meta_val, meta_rdy, data_val, data_rdy, data_last, err_drop;
  logic [IP_ADDR_W-1:0] src_ip, dst_ip;
  logic [TOT_LEN_W-1:0] pay_len;
  logic [PROTOCOL_W-1:0] proto;
  logic [XY_WIDTH-1:0] src_x, src_y;
  logic [MAC_INTERFACE_W-1:0] data;
  logic [MAC_PADBYTES_W-1:0] padbytes;
  logic [2:0] dbg_state;

  ip_tx_noc_in_parser #(.SRC_X(SX), .SRC_Y(SY)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .noc0_ctovr_parser_val    (noc_val),
    .noc0_ctovr_parser_data   (noc_data),
    .parser_noc0_ctovr_rdy    (noc_rdy),
    .parser_dst_meta_val      (meta_val),
    .parser_dst_src_ip        (src_ip),
    .parser_dst_dst_ip        (dst_ip),
    .parser_dst_payload_len   (pay_len),
    .parser_dst_protocol      (proto),
    .parser_dst_src_x         (src_x),
    .parser_dst_src_y         (src_y),
    .dst_parser_meta_rdy      (meta_rdy),
    .parser_dst_data_val      (data_val),
    .parser_dst_data          (data),
    .parser_dst_data_last     (data_last),
    .parser_dst_data_padbytes (padbytes),
    .dst_parser_data_rdy      (data_rdy),
    .parser_err_drop          (err_drop),
    .dbg_state_o              (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- scoreboard state ----------------
  logic [META_W-1:0] meta_q[$];
  logic [BEAT_W-1:0] beat_q[$];
  int err_exp = 0;
  int checks = 0;
  int errors = 0;
  int obs_meta, obs_meta_cyc, obs_beats, obs_last, obs_pad, obs_err;
  int last_beat_cyc, acc_cyc, hdr_cyc;
  int gap_max = 0;
  int meta_hold_left = 0;
  bit rand_mode = 0;

  // Sink: downstream ready generation.
  initial begin
    meta_rdy = 1'b1;
    data_rdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      data_rdy = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      meta_rdy = (meta_hold_left == 0);
    end
  end

  // Monitor: values sampled at negedge describe the transfer on the next posedge.
  logic [META_W-1:0] got_meta, exp_meta;
  logic [BEAT_W-1:0] got_beat, exp_beat;
  always @(negedge clk) begin
    if (rst_n) begin
      if (meta_val) begin
        obs_meta_cyc++;
        checks++;
        if (noc_rdy) begin
          errors++;
          $display("FAIL noc_rdy_meta_pending: got rdy=%0b want 0", noc_rdy);
        end
        if (meta_hold_left > 0) meta_hold_left--;
      end
      if (meta_val && meta_rdy) begin
        obs_meta++;
        checks++;
        got_meta = {src_ip, dst_ip, pay_len, proto, src_x, src_y};
        if (meta_q.size() == 0) begin
          errors++;
          $display("FAIL meta_unexpected: got %h want none", got_meta);
        end else begin
          exp_meta = meta_q.pop_front();
          if (got_meta !== exp_meta) begin
            errors++;
            $display("FAIL meta_fields: got %h want %h", got_meta, exp_meta);
          end
        end
      end
      if (data_val && !data_rdy) begin
        checks++;
        if (noc_rdy) begin
          errors++;
          $display("FAIL noc_rdy_data_blocked: got rdy=%0b want 0", noc_rdy);
        end
      end
      if (data_val && data_rdy) begin
        obs_beats++;
        if (data_last) begin
          obs_last++;
          obs_pad = int'(padbytes);
          last_beat_cyc = cyc + 1;
        end
        checks++;
        got_beat = {data_last, padbytes, data};
        if (beat_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got last=%0b pad=%0d want none", data_last, padbytes);
        end else begin
          exp_beat = beat_q.pop_front();
          if (got_beat !== exp_beat) begin
            errors++;
            $display("FAIL beat: got last=%0b pad=%0d d[31:0]=%h want last=%0b pad=%0d d[31:0]=%h",
                     got_beat[BEAT_W-1], got_beat[W +: MAC_PADBYTES_W], got_beat[31:0],
                     exp_beat[BEAT_W-1], exp_beat[W +: MAC_PADBYTES_W], exp_beat[31:0]);
          end
        end
      end
      if (err_drop) begin
        obs_err++;
        checks++;
        if (err_exp == 0) begin
          errors++;
          $display("FAIL err_drop_unexpected: got 1 want 0");
        end else begin
          err_exp--;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [W-1:0] rand_flit();
    logic [W-1:0] d;
    for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic send_flit(input logic [W-1:0] d);
    int n;
    int g;
    n = 0;
    g = $urandom_range(0, gap_max);
    for (int i = 0; i < g; i++) begin
      @(posedge clk); #1;
    end
    noc_val  = 1'b1;
    noc_data = d;
    @(negedge clk);
    while (!noc_rdy && n < 1000) begin
      n++;
      @(negedge clk);
    end
    if (!noc_rdy) begin
      checks++;
      errors++;
      $display("FAIL flit_accept_timeout: rdy=0 after %0d cycles want 1", n);
    end else begin
      acc_cyc = cyc + 1;
    end
    @(posedge clk); #1;
    noc_val = 1'b0;
  endtask

  function automatic logic [W-1:0] make_hdr(input logic [7:0] mtype, input int msg_len,
                                            input logic [7:0] dx, input logic [7:0] dy,
                                            input logic [7:0] mflits, input logic [7:0] sx,
                                            input logic [7:0] sy);
    beehive_noc_hdr_flit h;
    h = '0;
    h.dst_x = dx; h.dst_y = dy; h.msg_len = MSG_LENGTH_WIDTH'(msg_len);
    h.msg_type = mtype; h.src_x = sx; h.src_y = sy; h.metadata_flits = mflits;
    return h;
  endfunction

  function automatic logic [W-1:0] make_meta(input logic [31:0] sip, input logic [31:0] dip,
                                             input int len, input logic [7:0] pr);
    ip_tx_metadata_flit m;
    m = '0;
    m.src_ip = sip; m.dst_ip = dip; m.data_payload_len = TOT_LEN_W'(len); m.protocol = pr;
    return m;
  endfunction

  // Reference model: a message is accepted only if addressed to us with one meta flit;
  // its payload becomes ceil(len/64) beats, the last one padded to a full flit.
  task automatic send_msg(input logic [7:0] mtype, input int msg_len, input logic [7:0] dx,
                          input logic [7:0] dy, input logic [7:0] mflits, input int len,
                          input logic [7:0] pr, input logic [31:0] sip, input logic [31:0] dip);
    logic [7:0] sx, sy;
    logic [W-1:0] dq[$];
    logic [W-1:0] d;
    bit good;
    int beats, pad;
    sx = 8'($urandom());
    sy = 8'($urandom());
    good = (mtype == IP_TX_DATAGRAM) && (mflits == 8'd1) && (dx == 8'(SX)) && (dy == 8'(SY));
    if (good) begin
      meta_q.push_back({sip, dip, TOT_LEN_W'(len), pr, sx, sy});
      beats = (len + NOC_DATA_BYTES - 1) / NOC_DATA_BYTES;
      for (int i = 0; i < beats; i++) begin
        d = rand_flit();
        pad = (i == beats - 1) ? beats * NOC_DATA_BYTES - len : 0;
        beat_q.push_back({(i == beats - 1), MAC_PADBYTES_W'(pad), d});
        dq.push_back(d);
      end
    end else begin
      err_exp++;
    end
    send_flit(make_hdr(mtype, msg_len, dx, dy, mflits, sx, sy));
    hdr_cyc = acc_cyc;
    if (good) begin
      send_flit(make_meta(sip, dip, len, pr));
      while (dq.size() > 0) send_flit(dq.pop_front());
    end else begin
      for (int i = 0; i < msg_len; i++) send_flit(rand_flit());
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((meta_q.size() != 0 || beat_q.size() != 0 || err_exp != 0) && n < 2000) begin
      @(posedge clk); n++;
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (meta_q.size() != 0 || beat_q.size() != 0 || err_exp != 0) begin
      errors++;
      $display("FAIL drain: pending meta=%0d beats=%0d err=%0d want 0 0 0",
               meta_q.size(), beat_q.size(), err_exp);
    end
    checks++;
    if (dbg_state !== ST_RX_HDR) begin
      errors++;
      $display("FAIL idle_state: got %0d want %0d", dbg_state, ST_RX_HDR);
    end
  endtask

  task automatic clear_obs();
    obs_meta = 0; obs_meta_cyc = 0; obs_beats = 0; obs_last = 0; obs_pad = -1; obs_err = 0;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] mtype;
    int         msg_len;
    logic [7:0] dx, dy, mflits;
    int         len;
    logic [7:0] pr;
    int         exp_meta, exp_beats, exp_pad, exp_err;
  } vec_t;

  vec_t vecs[11];

  // Hard stop in case something stalls outside the bounded waits.
  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int t1;
    logic [W-1:0] d0, d1;
    vecs[0]  = '{IP_TX_DATAGRAM, 3, 8'd3, 8'd5, 8'd1, 100, 8'h11, 1, 2, 28, 0};
    vecs[1]  = '{IP_TX_DATAGRAM, 3, 8'd3, 8'd5, 8'd1, 128, 8'h06, 1, 2, 0, 0};
    vecs[2]  = '{IP_TX_DATAGRAM, 2, 8'd3, 8'd5, 8'd1, 64, 8'h11, 1, 1, 0, 0};
    vecs[3]  = '{IP_TX_DATAGRAM, 1, 8'd3, 8'd5, 8'd1, 0, 8'h11, 1, 0, 0, 0};
    vecs[4]  = '{8'h55, 4, 8'd3, 8'd5, 8'd1, 100, 8'h11, 0, 0, 0, 1};
    vecs[5]  = '{IP_TX_DATAGRAM, 2, 8'd3, 8'd5, 8'd1, 1, 8'h11, 1, 1, 63, 0};
    vecs[6]  = '{IP_TX_DATAGRAM, 2, 8'd4, 8'd5, 8'd1, 64, 8'h11, 0, 0, 0, 1};
    vecs[7]  = '{IP_TX_DATAGRAM, 0, 8'd3, 8'd5, 8'd2, 64, 8'h11, 0, 0, 0, 1};
    vecs[8]  = '{IP_TX_DATAGRAM, 3, 8'd3, 8'd5, 8'd1, 65, 8'h11, 1, 2, 63, 0};
    vecs[9]  = '{IP_TX_DATAGRAM, 25, 8'd3, 8'd5, 8'd1, 1500, 8'h11, 1, 24, 36, 0};
    vecs[10] = '{IP_TX_DATAGRAM, 2, 8'd3, 8'd6, 8'd1, 10, 8'h11, 0, 0, 0, 1};

    // Reset state.
    #12;
    check_int("reset_meta_val", int'(meta_val), 0);
    check_int("reset_data_val", int'(data_val), 0);
    check_int("reset_err_drop", int'(err_drop), 0);
    check_int("reset_state", int'(dbg_state), int'(ST_RX_HDR));
    check_int("reset_meta_regs", int'(|{src_ip, dst_ip, pay_len, proto, src_x, src_y}), 0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_int("rdy_after_reset", int'(noc_rdy), 1);
    @(posedge clk); #1;

    // Table-driven messages.
    foreach (vecs[i]) begin
      clear_obs();
      send_msg(vecs[i].mtype, vecs[i].msg_len, vecs[i].dx, vecs[i].dy, vecs[i].mflits,
               vecs[i].len, vecs[i].pr, 32'h0a000001, 32'h0a000002);
      wait_idle();
      check_int($sformatf("v%0d_meta_cnt", i), obs_meta, vecs[i].exp_meta);
      check_int($sformatf("v%0d_beats", i), obs_beats, vecs[i].exp_beats);
      check_int($sformatf("v%0d_last_cnt", i), obs_last, (vecs[i].exp_beats > 0) ? 1 : 0);
      if (vecs[i].exp_beats > 0) check_int($sformatf("v%0d_padbytes", i), obs_pad, vecs[i].exp_pad);
      check_int($sformatf("v%0d_err_pulses", i), obs_err, vecs[i].exp_err);
    end

    // Back-to-back: next header accepted the cycle after the last data beat.
    clear_obs();
    send_msg(IP_TX_DATAGRAM, 3, 8'd3, 8'd5, 8'd1, 128, 8'h11, 32'hc0a80001, 32'hc0a80002);
    t1 = last_beat_cyc;
    send_msg(IP_TX_DATAGRAM, 2, 8'd3, 8'd5, 8'd1, 64, 8'h11, 32'hc0a80003, 32'hc0a80004);
    wait_idle();
    check_int("b2b_hdr_cycle", hdr_cyc, t1 + 1);
    check_int("b2b_beats", obs_beats, 3);

    // Metadata held 5 cycles, downstream data ready random.
    clear_obs();
    meta_hold_left = 5;
    rand_mode = 1;
    send_msg(IP_TX_DATAGRAM, 6, 8'd3, 8'd5, 8'd1, 300, 8'h06, 32'h01020304, 32'h05060708);
    wait_idle();
    check_int("stall_meta_cycles", obs_meta_cyc, 6);
    check_int("stall_beats", obs_beats, 5);
    check_int("stall_padbytes", obs_pad, 20);

    // Randomized messages, some misaddressed.
    gap_max = 1;
    for (int m = 0; m < 30; m++) begin
      int len;
      int kind;
      len  = $urandom_range(0, 400);
      kind = $urandom_range(0, 5);
      meta_hold_left = $urandom_range(0, 3);
      if (kind == 0)
        send_msg(8'h33, $urandom_range(0, 5), 8'd3, 8'd5, 8'd1, len, 8'h11, $urandom(), $urandom());
      else if (kind == 1)
        send_msg(IP_TX_DATAGRAM, $urandom_range(0, 5), 8'd7, 8'd5, 8'd1, len, 8'h11, $urandom(), $urandom());
      else
        send_msg(IP_TX_DATAGRAM, 1 + (len + 63) / 64, 8'd3, 8'd5, 8'd1, len, 8'($urandom()),
                 $urandom(), $urandom());
    end
    wait_idle();
    gap_max = 0;
    rand_mode = 0;
    meta_hold_left = 0;
    repeat (2) @(posedge clk); #1;

    // Reset asserted in the middle of a payload.
    d0 = rand_flit();
    d1 = rand_flit();
    meta_q.push_back({32'h0a000009, 32'h0a00000a, 16'd256, 8'h11, 8'd1, 8'd2});
    beat_q.push_back({1'b0, 6'd0, d0});
    beat_q.push_back({1'b0, 6'd0, d1});
    send_flit(make_hdr(IP_TX_DATAGRAM, 5, 8'd3, 8'd5, 8'd1, 8'd1, 8'd2));
    send_flit(make_meta(32'h0a000009, 32'h0a00000a, 256, 8'h11));
    send_flit(d0);
    noc_val  = 1'b1;
    noc_data = d1;
    @(negedge clk);
    check_int("mid_data_val_before_reset", int'(data_val), 1);
    #2 rst_n = 1'b0;
    #1;
    check_int("async_reset_data_val", int'(data_val), 0);
    check_int("async_reset_meta_val", int'(meta_val), 0);
    check_int("async_reset_state", int'(dbg_state), int'(ST_RX_HDR));
    noc_val = 1'b0;
    meta_q.delete();
    beat_q.delete();
    err_exp = 0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    clear_obs();
    send_msg(IP_TX_DATAGRAM, 3, 8'd3, 8'd5, 8'd1, 100, 8'h11, 32'h0a000001, 32'h0a000002);
    wait_idle();
    check_int("post_reset_meta_cnt", obs_meta, 1);
    check_int("post_reset_beats", obs_beats, 2);
    check_int("post_reset_padbytes", obs_pad, 28);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
